// File: rtl/logic_accum_pkg.sv
// Shared encodings for the logic_accum fold engine: operation codes and FSM states.
// The optional LOGIC_ACCUM_ZERO_FLAG_EN build adds a zero flag; nothing here depends on it.
package logic_accum_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  // NAND folds as AND; the inversion is applied once to the final result.
  function automatic logic [1:0] fold_op(input logic [1:0] op);
    return (op == OP_NAND) ? OP_AND : op;
  endfunction

endpackage

// File: rtl/logic_accum_alu.sv
// Combinational fold step r = x OP y, bitwise over WIDTH bits.
// NAND is treated as AND here; the top applies the final inversion.
module logic_accum_alu
  import logic_accum_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] r
);

  always_comb begin
    r = x & y;
    unique case (fold_op(op))
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      default: r = x & y;
    endcase
  end

endmodule

// File: rtl/logic_accum.sv
// Folds COUNT operands into one bitwise AND/OR/XOR/NAND result per frame.
// Optional zero flag output enabled by defining LOGIC_ACCUM_ZERO_FLAG_EN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; the sender holds data stable while valid is high and ready is low.
module logic_accum
  import logic_accum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  parameter int CNT_W = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             busy
`ifdef LOGIC_ACCUM_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
  localparam bit               SINGLE   = (COUNT == 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] s_q;
  logic             out_valid_q;
  logic             zero_q;

  logic             in_xfer;
  logic             out_xfer;
  logic             last_xfer;
  logic [WIDTH-1:0] alu_r;
  logic [WIDTH-1:0] next_acc;
  logic [1:0]       frame_op;
  logic [WIDTH-1:0] result;

  logic_accum_alu #(.WIDTH(WIDTH)) u_alu (
    .op (op_q),
    .x  (acc_q),
    .y  (a),
    .r  (alu_r)
  );

  // in_ready is masked during reset so no operand can be taken that cycle.
  assign in_ready  = !reset && (state_q != DONE);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    next_acc  = alu_r;
    frame_op  = op_q;
    last_xfer = 1'b0;
    if (state_q == IDLE) begin
      next_acc  = a;
      frame_op  = op;
      last_xfer = in_xfer && SINGLE;
    end else if (state_q == ACCUM) begin
      last_xfer = in_xfer && (cnt_q == CNT_LAST);
    end
    result = (frame_op == OP_NAND) ? ~next_acc : next_acc;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_xfer) state_d = last_xfer ? DONE : ACCUM;
      end
      ACCUM: begin
        if (last_xfer) state_d = DONE;
      end
      DONE: begin
        if (out_xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_q        <= OP_AND;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_xfer) begin
        acc_q <= next_acc;
        if (state_q == IDLE) begin
          op_q  <= op;
          cnt_q <= CNT_W'(1);
        end else if (cnt_q < CNT_MAX) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      // The result is captured on the final operand so s never depends on a live input.
      if (last_xfer) begin
        s_q         <= result;
        out_valid_q <= 1'b1;
        zero_q      <= (result == '0);
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
        zero_q      <= 1'b0;
        cnt_q       <= '0;
      end
    end
  end

`ifdef LOGIC_ACCUM_ZERO_FLAG_EN
  assign zero = zero_q;
`else
  logic unused_zero;
  assign unused_zero = zero_q;
`endif

endmodule

// File: tb/tb_logic_accum.sv
// Directed bench for logic_accum (WIDTH=8, COUNT=4): frame table plus
// hand-written backpressure, op-change and reset sequences.
module tb_logic_accum;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] s;
  logic       busy;
`ifdef LOGIC_ACCUM_ZERO_FLAG_EN
  logic       zero;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  logic_accum #(.WIDTH(8), .COUNT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .busy      (busy)
`ifdef LOGIC_ACCUM_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op_first;
    logic [1:0]  op_rest;
    logic [31:0] ops;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input string n, input logic [1:0] o1, input logic [1:0] o2,
                              input logic [31:0] av, input logic [7:0] e);
    vec_t v;
    v.name = n; v.op_first = o1; v.op_rest = o2; v.ops = av; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: present one operand and hold it until accepted (bounded)
  task automatic send(input logic [7:0] av, input logic [1:0] ov);
    int w;
    in_valid = 1'b1; a = av; op = ov;
    w = 0;
    #1;
    while (!in_ready && w < 20) begin
      @(negedge clk); #1;
      w++;
    end
    if (w >= 20) check("in_ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] e;
    exp_q.push_back(v.exp);
    for (int i = 0; i < 4; i++) begin
      send(v.ops[31 - 8*i -: 8], (i == 0) ? v.op_first : v.op_rest);
      if (i < 3) begin
        #1;
        check({v.name, "_early_valid"}, out_valid, 0);
      end
    end
    in_valid = 1'b0;
    #1;
    e = exp_q.pop_front();
    check({v.name, "_out_valid"}, out_valid, 1);
    check({v.name, "_s"}, s, e);
    check({v.name, "_in_ready"}, in_ready, 0);
    check({v.name, "_busy"}, busy, 1);
`ifdef LOGIC_ACCUM_ZERO_FLAG_EN
    check({v.name, "_zero"}, zero, (e == 8'h00));
`endif
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(negedge clk); #1;
    check({name, "_drain_valid"}, out_valid, 0);
    check({name, "_drain_busy"}, busy, 0);
    check({name, "_drain_in_ready"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = mk("and",      2'b00, 2'b00, {8'hFF, 8'hF0, 8'h3C, 8'h1F}, 8'h10);
    vecs[1] = mk("or",       2'b01, 2'b01, {8'h01, 8'h02, 8'h04, 8'h80}, 8'h87);
    vecs[2] = mk("nand",     2'b11, 2'b11, {8'hFF, 8'hF0, 8'h3C, 8'h1F}, 8'hEF);
    vecs[3] = mk("xor",      2'b10, 2'b10, {8'hAA, 8'h55, 8'h0F, 8'hF0}, 8'h00);
    vecs[4] = mk("and_to_or",2'b00, 2'b01, {8'hFF, 8'h0F, 8'hFF, 8'hFF}, 8'h0F);
    vecs[5] = mk("xor_to_and",2'b10,2'b00, {8'h0F, 8'hF0, 8'hFF, 8'h01}, 8'h01);
    vecs[6] = mk("xor_small",2'b10, 2'b10, {8'h01, 8'h02, 8'h03, 8'h04}, 8'h04);
    vecs[7] = mk("nand_ones",2'b11, 2'b11, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'h00);

    reset = 1'b1; op = 2'b00; in_valid = 1'b1; a = 8'h5A; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_s", s, 0);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i]);
      consume(vecs[i].name);
    end

    // backpressure: result held while in_valid is asserted with a=00
    run_frame(vecs[0]);
    in_valid = 1'b1; a = 8'h00; op = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_s", s, 8'h10);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("bp_drained", out_valid, 0);
    check("bp_busy", busy, 0);
    run_frame(vecs[1]);
    consume("bp_next");

    // reset after two operands discards the partial frame
    send(8'h00, 2'b00);
    send(8'h00, 2'b00);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    reset = 1'b0;
    run_frame(mk("or_after_rst", 2'b01, 2'b01, {8'h10, 8'h20, 8'h40, 8'h01}, 8'h71));
    consume("or_after_rst");

    // reset while holding a result drops it
    run_frame(vecs[2]);
    reset = 1'b1;
    @(negedge clk); #1;
    check("donerst_out_valid", out_valid, 0);
    check("donerst_busy", busy, 0);
    check("donerst_s", s, 0);
    reset = 1'b0;
    run_frame(vecs[6]);
    consume("after_donerst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logic_accum.md
Name: logic_accum

Overview:
- Parametrised, clocked successor to the team's two-input combinational gates.
- Accepts a stream of WIDTH-bit operands through a valid/ready handshake and folds COUNT operands into one bitwise result. The fold operation is AND, OR, XOR or NAND, selected per frame.
- Presents the result on an output valid/ready handshake.
- Sits between operand producers and the result consumer in the lab datapath. It replaces chains of discrete gate instances.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- COUNT, 4, operands folded per result frame (>=1).
- CNT_W, $clog2(COUNT+1), operand counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- op  input  2  fold operation: 00 AND, 01 OR, 10 XOR, 11 NAND. Sampled only with the first operand of a frame.
- in_valid  input  1  operand a is valid.
- in_ready  output  1  block accepts an operand this cycle.
- a  input  WIDTH  operand.
- out_valid  output  1  result s is valid.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  folded result.
- busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. It overrides all other inputs in that cycle.
- Reset values: state=IDLE, acc=0, cnt=0, op_q=AND, s=0, out_valid=0, busy=0. in_ready=1 once reset deasserts.
- Transfers: an input transfer occurs on in_valid && in_ready at a rising edge. An output transfer occurs on out_valid && out_ready.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On input transfer: op_q<=op, acc<=a, cnt<=1.
  - Next state is DONE if COUNT==1, else ACCUM.
- State ACCUM:
  - in_ready=1.
  - On input transfer: acc<=acc OP a, where OP is AND for both AND and NAND. cnt<=cnt+1.
  - Moves to DONE when this transfer is operand number COUNT.
  - The op input is ignored in ACCUM; a mid-frame change has no effect.
- State DONE:
  - in_ready=0, out_valid=1.
  - s=acc, except s=~acc when op_q==NAND.
  - s and out_valid are held stable until the output transfer; in_valid is ignored.
  - On output transfer: return to IDLE, cnt<=0.
  - No same-cycle accept of the next frame's first operand. One bubble cycle per frame is intended.
- Latency: out_valid rises on the cycle after the COUNT-th input transfer. Throughput is one frame per COUNT+1 cycles when out_ready=1.
- Output registering: s and out_valid are driven from registered state. There is no combinational path from a or in_valid to s.
- Width rule: all operations are bitwise, WIDTH bits, with no carries. cnt saturates at COUNT and never wraps.
- Reset mid-frame: partial accumulation is discarded and the block returns to IDLE. The next accepted operand starts a fresh frame.
- Reset in DONE: out_valid drops in the same cycle reset is sampled, and the result is lost.
- in_valid is ignored entirely while reset is high.

Optional Feature:
- Macro: LOGIC_ACCUM_ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit). zero=1 iff out_valid && s==0, registered alongside s, and zero=0 on reset.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package logic_accum_pkg:
  - op encoding constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11.
  - state encoding IDLE/ACCUM/DONE.
- Sub-module logic_accum_alu:
  - combinational, parameter WIDTH, inputs op, x, y, output r.
  - Implements the fold step, with NAND mapped to AND.
  - Instantiated once in logic_accum.

Test Plan (WIDTH=8, COUNT=4):
- AND frame: op=00, a=FF,F0,3C,1F back-to-back -> s=8'h10, out_valid one cycle after the 4th transfer.
- OR then NAND frames: OR of 01,02,04,80 -> s=8'h87. NAND of FF,F0,3C,1F -> s=8'hEF.
- XOR frame: AA,55,0F,F0 -> s=8'h00; with LOGIC_ACCUM_ZERO_FLAG_EN, zero=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1, a=00 -> s and out_valid stable, in_ready=0, no operand consumed, next frame result unaffected.
- Mid-frame op change: start with op=00, switch op to 01 after the 1st operand, a=FF,0F,FF,FF -> s=8'h0F (AND kept).
- Reset mid-frame: reset=1 for 1 cycle after 2 operands -> busy=0, out_valid=0. Then a fresh OR frame 10,20,40,01 -> s=8'h71.
